// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op port for two's complement operation.
module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] part_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;

  logic               sop;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH:0]   trial;
  logic [WIDTH:0]     hi;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] part_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sop = signed_op;
`else
  assign sop = 1'b0;
`endif

  // The core always works on magnitudes; signs are restored on write-back.
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
    if (sop && dividend[WIDTH-1]) a_mag = {WIDTH{1'b0}} - dividend;
    if (sop && divisor[WIDTH-1])  b_mag = {WIDTH{1'b0}} - divisor;
  end

  // Keep the shifted-out bit so the trial compare never overflows.
  always_comb begin
    trial  = {part_q, 1'b0};
    hi     = trial[2*WIDTH:WIDTH];
    diff   = hi - {1'b0, dvs_q};
    part_d = trial[2*WIDTH-1:0];
    if (hi >= {1'b0, dvs_q}) begin
      part_d = {diff[WIDTH-1:0], trial[WIDTH-1:1], 1'b1};
    end
    quo_d = part_d[WIDTH-1:0];
    rem_d = part_d[2*WIDTH-1:WIDTH];
    if (qneg_q) quo_d = {WIDTH{1'b0}} - part_d[WIDTH-1:0];
    if (rneg_q) rem_d = {WIDTH{1'b0}} - part_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      part_q  <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            qneg_q <= sop & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q <= sop & dividend[WIDTH-1];
            if (divisor == '0) begin
              quo_q   <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              state_q <= FIN;
            end else begin
              dvs_q   <= b_mag;
              part_q  <= {{WIDTH{1'b0}}, a_mag};
              cnt_q   <= CNT_W'(WIDTH);
              dz_q    <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          part_q <= part_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule
